// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the memory-stage data RAM responder: FSM encoding,
// byte-enable geometry and the alignment helper.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned BeWidth    = 4;
    localparam int unsigned WordOffset = 2;
    localparam int unsigned CntWidth   = 4;

    function automatic logic is_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the memory stage (master) and the
// data RAM responder (slave).
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic               req_valid;
    logic               req_write;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [BeWidth-1:0] req_be;
    logic               req_ready;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_err;
    logic               stall_m;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall_m
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, stall_m
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port word RAM: synchronous byte-enabled write, registered read, no reset.
module data_mem_responder_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DepthLog2 = 10
) (
    input  logic                 clk_i,
    input  logic [DepthLog2-1:0] addr_i,
    input  logic                 we_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem [0:(1 << DepthLog2)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < BeWidth; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data RAM responder for the memory-stage load/store port: one request in
// flight, LATENCY wait states, a one-cycle response pulse and a stall to the hazard unit.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  mem_if
);

    localparam logic [CntWidth-1:0] CntInit = (LATENCY == 0) ? '0 : CntWidth'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  lat_write_q;
    logic                  lat_err_q;
    logic [DEPTH_LOG2-1:0] lat_idx_q;
    logic [31:0]           lat_wdata_q;
    logic [BeWidth-1:0]    lat_be_q;
    logic [31:0]           rdata_hold_q;

    logic                  accept;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  ram_we;
    logic [31:0]           ram_rdata;
    logic [31:0]           resp_data;
    logic                  unused_addr_bits;

    assign req_idx          = mem_if.req_addr[DEPTH_LOG2+1:WordOffset];
    assign unused_addr_bits = ^mem_if.req_addr[31:DEPTH_LOG2+2];
    assign accept           = (state_q == StIdle) && mem_if.req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_if.req_valid) begin
                    state_d = (LATENCY == 0) ? StResp : StWait;
                    cnt_d   = CntInit;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            lat_write_q  <= 1'b0;
            lat_err_q    <= 1'b0;
            lat_idx_q    <= '0;
            lat_wdata_q  <= '0;
            lat_be_q     <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_write_q <= mem_if.req_write;
                lat_err_q   <= !is_aligned(mem_if.req_addr[1:0]);
                lat_idx_q   <= req_idx;
                lat_wdata_q <= mem_if.req_wdata;
                lat_be_q    <= mem_if.req_be;
            end
            if (state_q == StResp) begin
                rdata_hold_q <= resp_data;
            end
        end
    end

    // In IDLE the RAM reads the incoming address so a zero-latency load has data in RESP.
    assign ram_addr  = (state_q == StIdle) ? req_idx : lat_idx_q;
    assign ram_we    = (state_q == StResp) && lat_write_q && !lat_err_q && reset;
    assign resp_data = (lat_write_q || lat_err_q) ? '0 : ram_rdata;

    data_mem_responder_array #(
        .DepthLog2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (lat_be_q),
        .wdata_i (lat_wdata_q),
        .rdata_o (ram_rdata)
    );

    assign mem_if.req_ready  = (state_q == StIdle);
    assign mem_if.resp_valid = (state_q == StResp);
    assign mem_if.resp_rdata = (state_q == StResp) ? resp_data : rdata_hold_q;
    assign mem_if.resp_err   = (state_q == StResp) && lat_err_q;
    assign mem_if.stall_m    = mem_if.req_valid && (state_q != StResp);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance, a transaction-level
// timeline/memory model checked every cycle, plus directed literal expectations.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        ready     [2];
    logic        resp_valid[2];
    logic [31:0] rdata     [2];
    logic        err       [2];
    logic        stall     [2];

    data_mem_responder_if if_a();
    data_mem_responder_if if_b();

    assign if_a.req_valid = req_valid[0];
    assign if_a.req_write = req_write[0];
    assign if_a.req_addr  = req_addr[0];
    assign if_a.req_wdata = req_wdata[0];
    assign if_a.req_be    = req_be[0];
    assign ready[0]       = if_a.req_ready;
    assign resp_valid[0]  = if_a.resp_valid;
    assign rdata[0]       = if_a.resp_rdata;
    assign err[0]         = if_a.resp_err;
    assign stall[0]       = if_a.stall_m;

    assign if_b.req_valid = req_valid[1];
    assign if_b.req_write = req_write[1];
    assign if_b.req_addr  = req_addr[1];
    assign if_b.req_wdata = req_wdata[1];
    assign if_b.req_be    = req_be[1];
    assign ready[1]       = if_b.req_ready;
    assign resp_valid[1]  = if_b.resp_valid;
    assign rdata[1]       = if_b.resp_rdata;
    assign err[1]         = if_b.resp_err;
    assign stall[1]       = if_b.stall_m;

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut_a (
        .clk    (clk),
        .reset  (rst_n),
        .mem_if (if_a)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut_b (
        .clk    (clk),
        .reset  (rst_n),
        .mem_if (if_b)
    );

    int tests_run = 0;
    int failed    = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Model: cycles left until the transaction finishes (1 = response cycle), word memory
    // with per-byte "known" flags, and the expected response of the transaction in flight.
    bit          live = 0;
    int          busy       [2] = '{0, 0};
    logic [31:0] exp_rdata  [2];
    logic        exp_err    [2];
    bit          exp_known  [2];
    logic [31:0] hold       [2] = '{32'd0, 32'd0};
    bit          hold_known [2] = '{1, 1};
    bit          pend_we    [2];
    int          pend_idx   [2];
    logic [31:0] pend_wdata [2];
    logic [3:0]  pend_be    [2];
    logic [31:0] mem_m      [2][1024];
    logic [3:0]  known      [2][1024];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) known[d][i] = 4'h0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    live          = 1;
                    busy[d]       = 0;
                    hold[d]       = 32'd0;
                    hold_known[d] = 1;
                end else if (busy[d] > 0) begin
                    if (busy[d] == 1) begin
                        hold[d]       = exp_rdata[d];
                        hold_known[d] = exp_known[d];
                        if (pend_we[d]) begin
                            for (int b = 0; b < 4; b++) begin
                                if (pend_be[d][b]) begin
                                    mem_m[d][pend_idx[d]][8*b +: 8] = pend_wdata[d][8*b +: 8];
                                    known[d][pend_idx[d]][b] = 1'b1;
                                end
                            end
                        end
                    end
                    busy[d]--;
                end else if (req_valid[d]) begin
                    pend_idx[d]   = int'(req_addr[d][11:2]);
                    exp_err[d]    = (req_addr[d][1:0] != 2'b00);
                    pend_we[d]    = req_write[d] && !exp_err[d];
                    pend_wdata[d] = req_wdata[d];
                    pend_be[d]    = req_be[d];
                    if (req_write[d] || exp_err[d]) begin
                        exp_rdata[d] = 32'd0;
                        exp_known[d] = 1;
                    end else begin
                        exp_rdata[d] = mem_m[d][pend_idx[d]];
                        exp_known[d] = (known[d][pend_idx[d]] == 4'hF);
                    end
                    busy[d] = lat_of(d) + 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                for (int d = 0; d < 2; d++) begin
                    chk("ready", d, {31'd0, ready[d]}, {31'd0, busy[d] == 0});
                    chk("resp_valid", d, {31'd0, resp_valid[d]}, {31'd0, busy[d] == 1});
                    chk("stall_m", d, {31'd0, stall[d]}, {31'd0, req_valid[d] && busy[d] != 1});
                    if (busy[d] == 1) begin
                        chk("resp_err", d, {31'd0, err[d]}, {31'd0, exp_err[d]});
                        if (exp_known[d]) chk("resp_rdata", d, rdata[d], exp_rdata[d]);
                    end else if (hold_known[d]) begin
                        chk("rdata_hold", d, rdata[d], hold[d]);
                    end
                end
            end
        end
    end

    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic e,
                       output int lat_n);
        int n;
        bit got;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        n = 0;
        @(negedge clk);
        while (!ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", d, {31'd0, ready[d]}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the in-flight transaction must not notice.
        req_valid[d] = 1'b0;
        req_write[d] = ~w;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
        req_be[d]    = ~be;
        got = 0;
        lat_n = 0;
        rd = 32'd0;
        e = 1'b0;
        while (!got && lat_n < 40) begin
            @(negedge clk);
            lat_n++;
            if (resp_valid[d]) begin
                got = 1;
                rd  = rdata[d];
                e   = err[d];
            end
        end
        chk("resp_wait", d, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat_n;
        int          accepts, resps, stall_low_bad, resp_cnt, last_acc, gap_bad, cyc;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 0, {31'd0, ready[0]}, 32'd1);
        chk("reset_resp_valid", 0, {31'd0, resp_valid[0]}, 32'd0);
        chk("reset_rdata", 0, rdata[0], 32'd0);
        chk("reset_err", 0, {31'd0, err[0]}, 32'd0);

        // Full-word store then load
        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat_n);
        chk("t1_store_err", 0, {31'd0, e}, 32'd0);
        chk("t1_store_rdata", 0, rd, 32'd0);
        chk("t1_store_lat", 0, lat_n, 32'd3);
        txn(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat_n);
        chk("t1_load_rdata", 0, rd, 32'hDEADBEEF);
        chk("t1_load_err", 0, {31'd0, e}, 32'd0);
        chk("t1_load_lat", 0, lat_n, 32'd3);

        // Partial byte-enable store merges into the existing word
        txn(0, 1, 32'h10, 32'h11223344, 4'b0101, rd, e, lat_n);
        txn(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat_n);
        chk("t2_merge", 0, rd, 32'hDE22BE44);

        // Misaligned load and store
        txn(0, 0, 32'h13, 32'h0, 4'h0, rd, e, lat_n);
        chk("t3_load_err", 0, {31'd0, e}, 32'd1);
        chk("t3_load_rdata", 0, rd, 32'd0);
        chk("t3_load_lat", 0, lat_n, 32'd3);
        txn(0, 1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, e, lat_n);
        chk("t3_store_err", 0, {31'd0, e}, 32'd1);
        txn(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat_n);
        chk("t3_word4_unchanged", 0, rd, 32'hDE22BE44);

        // Back-to-back loads with req_valid held high for 12 cycles
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        accepts = 0;
        resps = 0;
        stall_low_bad = 0;
        gap_bad = 0;
        last_acc = -1;
        for (cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (ready[0]) begin
                if (last_acc >= 0 && cyc - last_acc != 4) gap_bad++;
                last_acc = cyc;
                accepts++;
            end
            if (resp_valid[0]) begin
                resps++;
                chk("t4_rdata", 0, rdata[0], 32'hDE22BE44);
            end
            if (!stall[0] && !resp_valid[0]) stall_low_bad++;
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("t4_accepts", 0, accepts, 32'd3);
        chk("t4_resps", 0, resps, 32'd3);
        chk("t4_ready_gap", 0, gap_bad, 32'd0);
        chk("t4_stall_low_only_resp", 0, stall_low_bad, 32'd0);

        // Reset during WAIT of a store drops it
        txn(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat_n);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h55555555;
        req_be[0]    = 4'hF;
        @(negedge clk);
        chk("t5_accept_ready", 0, {31'd0, ready[0]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        resp_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            resp_cnt += int'(resp_valid[0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_after_reset", 0, {31'd0, ready[0]}, 32'd1);
        repeat (4) begin
            resp_cnt += int'(resp_valid[0]);
            @(negedge clk);
        end
        chk("t5_no_resp", 0, resp_cnt, 32'd0);
        txn(0, 0, 32'h20, 32'h0, 4'h0, rd, e, lat_n);
        chk("t5_word8_unchanged", 0, rd, 32'hCAFEF00D);

        // Zero-latency instance and address aliasing above DEPTH_LOG2+1
        txn(1, 1, 32'h10, 32'h0BADC0DE, 4'hF, rd, e, lat_n);
        chk("t6_store_lat", 1, lat_n, 32'd1);
        txn(1, 0, 32'h1010, 32'h0, 4'h0, rd, e, lat_n);
        chk("t6_alias_rdata", 1, rd, 32'h0BADC0DE);
        chk("t6_alias_err", 1, {31'd0, e}, 32'd0);
        chk("t6_load_lat", 1, lat_n, 32'd1);
        txn(0, 0, 32'h1010, 32'h0, 4'h0, rd, e, lat_n);
        chk("t6_alias_lat2", 0, rd, 32'hDE22BE44);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
